// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Register scoreboard for the decode stage. Every in-flight destination
// register carries a busy bit and a latency countdown. The issue-side hazard
// check (RAW per source, WAW on the destination) is purely combinational
// against the registered table. Variable-latency producers and optional
// forwarding therefore need no knowledge of the pipeline depth.
//
// Ports
//   clk          : system clock
//   rst          : asynchronous reset, active low
//   iss_valid    : ID holds an instruction requesting issue
//   iss_src_idx  : NSRC packed source indices, source k at [k*IDX_W +: IDX_W]
//   iss_src_used : per-source enable; an unused source never stalls
//   iss_dest_idx : destination register index
//   iss_dest_wr  : instruction writes its destination
//   iss_lat      : cycles from issue until the result is forwardable
//   wb_valid     : a write-back happens this cycle
//   wb_idx       : register being written back
//   flush        : squash every in-flight entry
//   stall        : combinational, issue must be held
//   iss_fire     : iss_valid & ~stall & ~flush
//   busy_vec     : registered busy bits (bit 0 always 0)
//   pend_cnt     : registered population count of busy_vec
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NREG      = 32,
    parameter int IDX_W     = $clog2(NREG),
    parameter int NSRC      = 2,
    parameter int LAT_W     = 3,
    parameter int FWD_EN    = 0,
    parameter int WB_BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [NSRC*IDX_W-1:0] iss_src_idx,
    input  logic [NSRC-1:0]       iss_src_used,
    input  logic [IDX_W-1:0]      iss_dest_idx,
    input  logic                  iss_dest_wr,
    input  logic [LAT_W-1:0]      iss_lat,
    input  logic                  wb_valid,
    input  logic [IDX_W-1:0]      wb_idx,
    input  logic                  flush,
    output logic                  stall,
    output logic                  iss_fire,
    output logic [NREG-1:0]       busy_vec,
    output logic [IDX_W:0]        pend_cnt
);

    // The index space may be larger than NREG; lookups go through vectors
    // padded to the full index range so out-of-range indices read as idle.
    localparam int NIDX = 1 << IDX_W;

    logic [NREG-1:0]  busy_reg;
    logic [NREG-1:0]  busy_next;
    logic [LAT_W-1:0] cnt_reg  [NREG-1:1];
    logic [LAT_W-1:0] cnt_next [NREG-1:1];
    logic [IDX_W:0]   pend_cnt_reg;
    logic [IDX_W:0]   pend_cnt_next;

    logic [NIDX-1:0]  busy_ext;
    logic [NIDX-1:0]  cnt_nz_ext;
    logic [NSRC-1:0]  src_haz;
    logic             waw_haz;
    logic             load_en;

    // ------------------------------------------------------------------
    // Padded lookup vectors (entry 0 and unimplemented indices never busy)
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NIDX; gi++) begin : g_ext
            if (gi > 0 && gi < NREG) begin : g_real
                assign busy_ext[gi]   = busy_reg[gi];
                assign cnt_nz_ext[gi] = |cnt_reg[gi];
            end else begin : g_pad
                assign busy_ext[gi]   = 1'b0;
                assign cnt_nz_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Source (RAW) hazards: one table lookup and compare per source
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            logic [IDX_W-1:0] src_idx;
            logic             still_pending;
            logic             wb_unblock;

            assign src_idx = iss_src_idx[gi*IDX_W +: IDX_W];

            // Without forwarding the operand waits for write-back; with it,
            // the operand is ready once the countdown has drained.
            assign still_pending = (FWD_EN == 0) || cnt_nz_ext[src_idx];

            // A write-back of this very register in the current cycle can
            // supply the operand directly.
            assign wb_unblock = (WB_BYPASS != 0) && wb_valid && (wb_idx == src_idx);

            assign src_haz[gi] = iss_src_used[gi]
                              && (src_idx != '0)
                              && busy_ext[src_idx]
                              && still_pending
                              && !wb_unblock;
        end
    endgenerate

    // WAW keeps completion in order per register; no bypass applies here.
    assign waw_haz = iss_dest_wr && (iss_dest_idx != '0) && busy_ext[iss_dest_idx];

    assign stall    = iss_valid && ((|src_haz) || waw_haz);
    assign iss_fire = iss_valid && !stall && !flush;
    assign load_en  = iss_fire && iss_dest_wr;

    // ------------------------------------------------------------------
    // Per-entry next state. Priority: flush, issue load, retire, countdown.
    // Issue beats retire on the same index so a fresh producer is never
    // lost to a stale write-back.
    // ------------------------------------------------------------------
    assign busy_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
            logic load_hit;
            logic wb_hit;
            logic cnt_dec;

            assign load_hit = load_en && (iss_dest_idx == IDX_W'(gi));
            assign wb_hit   = wb_valid && (wb_idx == IDX_W'(gi));
            assign cnt_dec  = busy_reg[gi] && (cnt_reg[gi] != '0);

            assign busy_next[gi] = flush    ? 1'b0 :
                                   load_hit ? 1'b1 :
                                   wb_hit   ? 1'b0 :
                                              busy_reg[gi];

            assign cnt_next[gi]  = flush    ? '0 :
                                   load_hit ? iss_lat :
                                   wb_hit   ? '0 :
                                   cnt_dec  ? cnt_reg[gi] - LAT_W'(1) :
                                              cnt_reg[gi];
        end
    endgenerate

    // Population count of the next busy vector, so pend_cnt and busy_vec
    // change on the same edge.
    always_comb begin
        pend_cnt_next = '0;
        for (int i = 1; i < NREG; i++) begin
            pend_cnt_next = pend_cnt_next + {{IDX_W{1'b0}}, busy_next[i]};
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg     <= '0;
            pend_cnt_reg <= '0;
            for (int i = 1; i < NREG; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            busy_reg     <= busy_next;
            pend_cnt_reg <= pend_cnt_next;
            for (int i = 1; i < NREG; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    assign busy_vec = busy_reg;
    assign pend_cnt = pend_cnt_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Two scoreboards share one directed stimulus stream:
//   dut_a : FWD_EN=0, WB_BYPASS=0
//   dut_b : FWD_EN=1, WB_BYPASS=1
// A reference model tracks, per register, whether it is pending and the
// absolute edge number at which its result becomes forwardable. Every falling
// edge the outputs of both DUTs are compared with the model; the stimulus
// also carries hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

    localparam int NREG  = 32;
    localparam int IDX_W = 5;
    localparam int NSRC  = 2;
    localparam int LAT_W = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  iss_valid;
    logic [NSRC*IDX_W-1:0] iss_src_idx;
    logic [NSRC-1:0]       iss_src_used;
    logic [IDX_W-1:0]      iss_dest_idx;
    logic                  iss_dest_wr;
    logic [LAT_W-1:0]      iss_lat;
    logic                  wb_valid;
    logic [IDX_W-1:0]      wb_idx;
    logic                  flush;

    logic                  stall_a, fire_a, stall_b, fire_b;
    logic [NREG-1:0]       busy_a, busy_b;
    logic [IDX_W:0]        pend_a, pend_b;

    always #5 clk = ~clk;

    reg_scoreboard #(
        .NREG(NREG), .IDX_W(IDX_W), .NSRC(NSRC), .LAT_W(LAT_W),
        .FWD_EN(0), .WB_BYPASS(0)
    ) dut_a (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_src_idx(iss_src_idx),
        .iss_src_used(iss_src_used), .iss_dest_idx(iss_dest_idx),
        .iss_dest_wr(iss_dest_wr), .iss_lat(iss_lat),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .flush(flush),
        .stall(stall_a), .iss_fire(fire_a),
        .busy_vec(busy_a), .pend_cnt(pend_a)
    );

    reg_scoreboard #(
        .NREG(NREG), .IDX_W(IDX_W), .NSRC(NSRC), .LAT_W(LAT_W),
        .FWD_EN(1), .WB_BYPASS(1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_src_idx(iss_src_idx),
        .iss_src_used(iss_src_used), .iss_dest_idx(iss_dest_idx),
        .iss_dest_wr(iss_dest_wr), .iss_lat(iss_lat),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .flush(flush),
        .stall(stall_b), .iss_fire(fire_b),
        .busy_vec(busy_b), .pend_cnt(pend_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Config 0 = no forwarding/no bypass, 1 = both on.
    // m_ready holds the edge count from which the result is forwardable.
    // ------------------------------------------------------------------
    bit m_busy  [2][NREG];
    int m_ready [2][NREG];
    int edge_cnt = 0;

    function automatic bit src_blocked(input int c, input int s);
        bit fwd;
        bit byp;
        fwd = (c == 1);
        byp = (c == 1);
        if (s == 0 || !m_busy[c][s]) return 1'b0;
        if (fwd && edge_cnt >= m_ready[c][s]) return 1'b0;
        if (byp && wb_valid && int'(wb_idx) == s) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_stall(input int c);
        if (!iss_valid) return 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (iss_src_used[k] && src_blocked(c, int'(iss_src_idx[k*IDX_W +: IDX_W])))
                return 1'b1;
        end
        if (iss_dest_wr && iss_dest_idx != 0 && m_busy[c][iss_dest_idx]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < NREG; i++)
                    m_busy[c][i] <= 1'b0;
        end else begin
            edge_cnt <= edge_cnt + 1;
            for (int c = 0; c < 2; c++) begin
                if (flush) begin
                    for (int i = 0; i < NREG; i++) m_busy[c][i] <= 1'b0;
                end else begin
                    if (wb_valid && wb_idx != 0) m_busy[c][wb_idx] <= 1'b0;
                    if (iss_valid && !exp_stall(c) && iss_dest_wr && iss_dest_idx != 0) begin
                        m_busy[c][iss_dest_idx]  <= 1'b1;
                        m_ready[c][iss_dest_idx] <= edge_cnt + 1 + int'(iss_lat);
                    end
                end
            end
        end
    end

    task automatic cmp(input int c, input logic st, input logic fi,
                       input logic [NREG-1:0] bv, input logic [IDX_W:0] pc);
        bit             es;
        logic [NREG-1:0] eb;
        int             ep;
        es = exp_stall(c);
        eb = '0;
        ep = 0;
        for (int i = 0; i < NREG; i++) begin
            if (m_busy[c][i]) begin
                eb[i] = 1'b1;
                ep++;
            end
        end
        chk($sformatf("cfg%0d stall", c), 64'(st), 64'(es));
        chk($sformatf("cfg%0d iss_fire", c), 64'(fi), 64'(iss_valid && !es && !flush));
        chk($sformatf("cfg%0d busy_vec", c), 64'(bv), 64'(eb));
        chk($sformatf("cfg%0d pend_cnt", c), 64'(pc), 64'(ep));
    endtask

    always @(negedge clk) begin
        cmp(0, stall_a, fire_a, busy_a, pend_a);
        cmp(1, stall_b, fire_b, busy_b, pend_b);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drv(input logic v, input int s0, input int s1, input logic [1:0] used,
                       input int d, input logic wr, input int lat,
                       input logic wbv, input int wbi, input logic fl);
        iss_valid    = v;
        iss_src_idx  = {IDX_W'(s1), IDX_W'(s0)};
        iss_src_used = used;
        iss_dest_idx = IDX_W'(d);
        iss_dest_wr  = wr;
        iss_lat      = LAT_W'(lat);
        wb_valid     = wbv;
        wb_idx       = IDX_W'(wbi);
        flush        = fl;
    endtask

    task automatic idle();
        drv(1'b0, 0, 0, 2'b00, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    int flush_dest [5] = '{1, 2, 10, 11, 12};

    initial begin
        idle();
        nxt();
        nxt();
        #1;
        chk("reset busy_vec", 64'(busy_a), 64'd0);
        chk("reset pend_cnt", 64'(pend_b), 64'd0);
        rst = 1'b1;
        nxt();

        // RAW: x3 with latency 2, dependent presented every cycle
        drv(1, 0, 0, 2'b00, 3, 1, 2, 0, 0, 0); nxt();
        drv(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0); #1;
        chk("raw a stall c1", 64'(stall_a), 64'd1);
        chk("raw b stall c1", 64'(stall_b), 64'd1);
        chk("raw a busy c1", 64'(busy_a), 64'h8);
        chk("raw a pend c1", 64'(pend_a), 64'd1);
        nxt();
        drv(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0); #1;
        chk("raw b stall c2", 64'(stall_b), 64'd1);
        nxt();
        drv(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0); #1;
        chk("raw b stall c3", 64'(stall_b), 64'd0);
        chk("raw a stall c3", 64'(stall_a), 64'd1);
        nxt();
        drv(1, 3, 0, 2'b01, 0, 0, 0, 1, 3, 0); #1;
        chk("raw a stall wb", 64'(stall_a), 64'd1);
        nxt();
        drv(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0); #1;
        chk("raw a stall post wb", 64'(stall_a), 64'd0);
        chk("raw a fire post wb", 64'(fire_a), 64'd1);
        chk("raw a busy post wb", 64'(busy_a), 64'd0);
        nxt();

        // Forwarding: x4 latency 3
        drv(1, 0, 0, 2'b00, 4, 1, 3, 0, 0, 0); nxt();
        drv(1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0); #1;
        chk("fwd b stall N", 64'(stall_b), 64'd1);
        nxt();
        nxt();
        #1;
        chk("fwd b stall N+2", 64'(stall_b), 64'd1);
        nxt();
        #1;
        chk("fwd b stall N+3", 64'(stall_b), 64'd0);
        chk("fwd b fire N+3", 64'(fire_b), 64'd1);
        chk("fwd a stall N+3", 64'(stall_a), 64'd1);
        nxt();
        drv(0, 0, 0, 2'b00, 0, 0, 0, 1, 4, 0); nxt();

        // WAW and same-cycle bypass on x6
        drv(1, 0, 0, 2'b00, 6, 1, 7, 0, 0, 0); nxt();
        drv(1, 0, 0, 2'b00, 6, 1, 1, 0, 0, 0); #1;
        chk("waw a stall", 64'(stall_a), 64'd1);
        chk("waw b stall", 64'(stall_b), 64'd1);
        nxt();
        drv(1, 6, 0, 2'b01, 6, 1, 1, 1, 6, 0); #1;
        chk("waw b stall with wb", 64'(stall_b), 64'd1);
        nxt();
        drv(1, 0, 0, 2'b00, 6, 1, 7, 0, 0, 0); #1;
        chk("waw a reissue fire", 64'(fire_a), 64'd1);
        chk("waw b reissue fire", 64'(fire_b), 64'd1);
        nxt();
        drv(1, 6, 0, 2'b01, 8, 1, 1, 1, 6, 0); #1;
        chk("bypass b stall", 64'(stall_b), 64'd0);
        chk("bypass b fire", 64'(fire_b), 64'd1);
        chk("bypass a stall", 64'(stall_a), 64'd1);
        nxt();
        drv(0, 0, 0, 2'b00, 0, 0, 0, 1, 8, 0); nxt();

        // x0 destination and unused sources
        drv(1, 0, 0, 2'b00, 0, 1, 5, 0, 0, 0); nxt();
        drv(1, 0, 0, 2'b00, 9, 1, 4, 0, 0, 0); #1;
        chk("x0 a busy", 64'(busy_a), 64'd0);
        chk("x0 b busy", 64'(busy_b), 64'd0);
        nxt();
        drv(1, 9, 9, 2'b00, 0, 0, 0, 0, 0, 0); #1;
        chk("unused a stall", 64'(stall_a), 64'd0);
        chk("unused b stall", 64'(stall_b), 64'd0);
        chk("unused b busy", 64'(busy_b), 64'h200);
        nxt();
        drv(0, 0, 0, 2'b00, 0, 0, 0, 1, 9, 0); nxt();

        // Flush with five pending entries
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 0, 2'b00, flush_dest[i], 1, 3, 0, 0, 0);
            nxt();
        end
        drv(1, 0, 0, 2'b00, 13, 1, 2, 1, 2, 1); #1;
        chk("flush a pend before", 64'(pend_a), 64'd5);
        chk("flush b pend before", 64'(pend_b), 64'd5);
        chk("flush a fire", 64'(fire_a), 64'd0);
        chk("flush b fire", 64'(fire_b), 64'd0);
        nxt();
        idle(); #1;
        chk("flush a busy after", 64'(busy_a), 64'd0);
        chk("flush a pend after", 64'(pend_a), 64'd0);
        chk("flush b pend after", 64'(pend_b), 64'd0);
        nxt();

        // Reset mid-operation with x5 and x7 busy
        drv(1, 0, 0, 2'b00, 5, 1, 2, 0, 0, 0); nxt();
        drv(1, 0, 0, 2'b00, 7, 1, 2, 0, 0, 0); nxt();
        idle(); #1;
        chk("pre-reset a busy", 64'(busy_a), 64'hA0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid reset a busy", 64'(busy_a), 64'd0);
        chk("mid reset a pend", 64'(pend_a), 64'd0);
        chk("mid reset b busy", 64'(busy_b), 64'd0);
        #1;
        rst = 1'b1;
        nxt();
        drv(1, 5, 7, 2'b11, 1, 1, 2, 0, 0, 0); #1;
        chk("after reset a stall", 64'(stall_a), 64'd0);
        chk("after reset b stall", 64'(stall_b), 64'd0);
        chk("after reset a fire", 64'(fire_a), 64'd1);
        nxt();
        drv(0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0); nxt();
        idle(); nxt();
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register scoreboard that replaces the fixed three-stage index-compare stall in the decode stage. It tracks every in-flight destination register with a busy bit and a latency countdown, so variable-latency units (MUL/MULHU, loads) and optional forwarding are handled without hard-coding pipeline depth. It sits beside the register file in ID. Issue is accepted when `iss_fire` is high, entries are retired by the WB stage, and `flush` clears the table.

## Interface
- `NREG`, 32: number of architectural registers.
- `IDX_W`, `$clog2(NREG)`: register index width.
- `NSRC`, 2: source operands checked per issue.
- `LAT_W`, 3: width of the latency field and the per-entry counter.
- `FWD_EN`, 0: 1 means a source becomes ready when its counter reaches 0; 0 means it stays blocked until write-back.
- `WB_BYPASS`, 1: 1 means a write-back in the current cycle unblocks a matching source in that same cycle.

- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-low reset.
- `iss_valid` in 1: ID holds an instruction requesting issue.
- `iss_src_idx` in NSRC*IDX_W: source indices, with source k at bits [k*IDX_W +: IDX_W].
- `iss_src_used` in NSRC: per-source enable. An unused source never stalls.
- `iss_dest_idx` in IDX_W: destination index.
- `iss_dest_wr` in 1: the instruction writes its destination.
- `iss_lat` in LAT_W: cycles from issue until the result is forwardable.
- `wb_valid` in 1: a write-back is occurring this cycle.
- `wb_idx` in IDX_W: index being written back.
- `flush` in 1: squash all in-flight entries.
- `stall` out 1: the issue must be held.
- `iss_fire` out 1: equals `iss_valid & ~stall & ~flush`.
- `busy_vec` out NREG: registered busy bits. Bit 0 is always 0.
- `pend_cnt` out IDX_W+1: registered population count of `busy_vec`.

## Operation
- **Per-entry state.** Each register i ≥ 1 holds a `busy[i]` bit and a `cnt[i]` counter of LAT_W bits.
- **Register 0.** Never becomes busy and never causes a stall.
- **Source hazard.** Source k is blocked when all of the following hold:
  - `iss_src_used[k]` is set, the index s ≠ 0, and `busy[s]` is set;
  - `FWD_EN`=0, or `cnt[s]` ≠ 0;
  - not (`WB_BYPASS`=1 and `wb_valid` and `wb_idx`==s).
- **WAW hazard.** `iss_dest_wr` is set, `iss_dest_idx` ≠ 0 and `busy[iss_dest_idx]` is set. This keeps in-order completion per register.
- **Stall.** `stall` = `iss_valid` & (any source hazard | WAW hazard). It is combinational and is 0 when `iss_valid`=0.
- **Issue.** On `iss_fire` with `iss_dest_wr` set and dest ≠ 0: set `busy[dest]` and load `cnt[dest]` = `iss_lat`. The loaded value is not decremented on that edge.
- **Countdown.** Every edge, each busy entry with `cnt` ≠ 0 that is not being loaded decrements by 1. It saturates at 0 and never wraps.
- **Retire.** On `wb_valid`, clear `busy[wb_idx]` and `cnt[wb_idx]`. A `wb_idx` that is not busy is a no-op, and `wb_idx`=0 is ignored.
- **Issue and retire on the same index in the same edge.** Issue wins: the entry is busy with `cnt`=`iss_lat`. This cannot happen for a legal stream because of the WAW hazard, but it is still defined.
- **Flush.** On the edge where `flush`=1, all busy and cnt bits clear. Any write-back in that cycle is absorbed. No issue is accepted in that cycle.
- **`iss_lat`=0.** The entry is forward-ready from the next cycle when `FWD_EN`=1.

## Timing
- **Reset.** While `rst`=0, asynchronously: all busy=0, all cnt=0, `busy_vec`=0, `pend_cnt`=0. `stall` and `iss_fire` follow their inputs combinationally.
- **Reset mid-operation.** All entries drop immediately. The first edge after release behaves as an empty table.
- **Issue to visibility.** An issue at edge N sets `busy_vec`/`pend_cnt` after edge N. A dependent instruction presented in the next cycle sees the hazard.
- **Forward readiness (`FWD_EN`=1).** With `iss_lat`=L issued at edge N, a dependent source is unblocked in the cycle after edge N+L.
- **Write-back unblock.** A write-back in cycle C unblocks in cycle C when `WB_BYPASS`=1, otherwise in C+1.
- **`pend_cnt` range.** 0..NREG-1, updated in the same edge as `busy_vec`.
- **Stall path.** No register between `stall` and its inputs. Its logic depth is one NREG:1 mux plus compare per source.

## Test plan
- **Reset.** Assert `rst`=0 mid-stream with x5 and x7 busy. Required: `busy_vec`=0 and `pend_cnt`=0 immediately. After release, issuing `add x1,x5,x7` gives `stall`=0.
- **RAW without forwarding.** `FWD_EN`=0, `WB_BYPASS`=0. Issue dest x3 with lat 2, then a source x3 every cycle. Required: `stall`=1 until the cycle after `wb_valid`/`wb_idx`=3, then `iss_fire`=1.
- **RAW with forwarding.** `FWD_EN`=1. Issue dest x4 with lat 3 at edge N, then a dependent on x4. Required: `stall`=1 during the cycles after edges N..N+2, and 0 after edge N+3, with no write-back needed.
- **WAW and same-cycle bypass.** x6 is busy; issue dest x6. Required: `stall`=1. With `WB_BYPASS`=1, `wb_valid`, `wb_idx`=6 and a source of x6 in the same cycle, the source hazard clears and the stall remains from WAW only. With dest ≠ x6 in that cycle, `stall`=0.
- **x0 and unused sources.** Dest x0 with lat 5 leaves `busy_vec`=0. A source index 9 with `iss_src_used`=0 while x9 is busy gives `stall`=0.
- **Flush.** Five regs busy (`pend_cnt`=5). Assert `flush` with `iss_valid`=1 and `wb_valid`, `wb_idx`=2. Required: `iss_fire`=0 that cycle; next cycle `busy_vec`=0 and `pend_cnt`=0.
